// File: rtl/cp0_pkg.sv
// CP0 register numbers, exception codes and handler entry shared by the P7
// pipeline.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0.sv
// Coprocessor 0 for the P7 M stage: SR/Cause/EPC/PRId, interrupt and
// exception arbitration, EPC capture and the redirect request.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h2022_0819
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Din,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] Dout,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic [31:0] sr;
  logic [31:0] cause;
  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_next;

  assign sr    = {16'h0, im, 8'h0, exl, ie};
  assign cause = {bd, 15'h0, ip, 3'h0, exc_code, 2'b00};

  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (ExcCodeIn != EXC_INT) & ~exl;
  assign Req     = int_req | exc_req;

  // A delay-slot fault restarts at the branch, not the slot.
  assign epc_next = BDIn ? (PC - 32'd4) : PC;
  assign EPCOut   = epc;

  always_comb begin
    Dout = 32'h0;
    case (A1)
      CP0_SR:    Dout = sr;
      CP0_CAUSE: Dout = cause;
      CP0_EPC:   Dout = epc;
      CP0_PRID:  Dout = PRID;
      default:   Dout = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        exl      <= 1'b1;
        exc_code <= int_req ? EXC_INT : ExcCodeIn;
        bd       <= BDIn;
        epc      <= {epc_next[31:2], 2'b00};
      end else begin
        if (EXLClr)
          exl <= 1'b0;
        if (WE) begin
          case (A2)
            CP0_SR: begin
              im <= Din[15:10];
              ie <= Din[0];
              if (!EXLClr)
                exl <= Din[1];
            end
            CP0_EPC: epc <= {Din[31:2], 2'b00};
            default: ;
          endcase
        end
      end
    end
  end

endmodule
